// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU encodings used by the write-back stage and its helpers
package cpu_pkg;

    // GPR address width and the hard-wired zero register
    localparam int GPR_AW = 5;
    localparam logic [GPR_AW-1:0] REG_ZERO = '0;

    // Load-type encodings as carried down the pipeline from decode
    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_H  = 3'd1,
        LD_HU = 3'd2,
        LD_B  = 3'd3,
        LD_BU = 3'd4
    } ld_type_e;

    // Number of valid lanes in a two-lane bundle (0, 1 or 2)
    function automatic logic [1:0] lanes_valid(input logic v1, input logic v2);
        return {1'b0, v1} + {1'b0, v2};
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: extracts the addressed byte/half of a little-endian word and extends it
module load_align
    import cpu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rdata_i,
    input  logic [2:0]    ld_type_i,
    input  logic [1:0]    addr_lo_i,
    output logic [DW-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Half-word alignment uses only addr_lo[1]; misaligned halves never reach WB
    assign byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    // Sign- or zero-extend by load type; unknown codes behave as a full word
    always_comb begin
        data_o = rdata_i;
        case (ld_type_i)
            LD_B:    data_o = {{(DW-8){byte_v[7]}}, byte_v};
            LD_BU:   data_o = {{(DW-8){1'b0}}, byte_v};
            LD_H:    data_o = {{(DW-16){half_v[15]}}, half_v};
            LD_HU:   data_o = {{(DW-16){1'b0}}, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: dual-issue write-back registers with WAW resolution and retire counter
module wb_stage
    import cpu_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = GPR_AW,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid_1,
    input  logic             mem_valid_2,
    input  logic             mem_w_en_1,
    input  logic             mem_w_en_2,
    input  logic [AW-1:0]    mem_w_addr_1,
    input  logic [AW-1:0]    mem_w_addr_2,
    input  logic [DW-1:0]    mem_alu_data_1,
    input  logic [DW-1:0]    mem_alu_data_2,
    input  logic             mem_is_load_1,
    input  logic             mem_is_load_2,
    input  logic [2:0]       mem_ld_type_1,
    input  logic [2:0]       mem_ld_type_2,
    input  logic [1:0]       mem_addr_lo_1,
    input  logic [1:0]       mem_addr_lo_2,
    input  logic [DW-1:0]    dm_rdata_1,
    input  logic [DW-1:0]    dm_rdata_2,
    input  logic             wb_stall,
    input  logic             wb_flush,
    output logic             reg_w_en_1,
    output logic             reg_w_en_2,
    output logic [AW-1:0]    reg_w_addr_1,
    output logic [AW-1:0]    reg_w_addr_2,
    output logic [DW-1:0]    reg_w_data_1,
    output logic [DW-1:0]    reg_w_data_2,
    output logic [CNT_W-1:0] wb_retire_cnt
);

    logic             en_1_q, en_2_q, en_1_d, en_2_d;
    logic [AW-1:0]    addr_1_q, addr_2_q;
    logic [DW-1:0]    data_1_q, data_2_q, data_1_d, data_2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    ld_data_1, ld_data_2;
    logic             wr_1, wr_2;

    load_align #(.DW(DW)) u_align_1 (
        .rdata_i   (dm_rdata_1),
        .ld_type_i (mem_ld_type_1),
        .addr_lo_i (mem_addr_lo_1),
        .data_o    (ld_data_1)
    );

    load_align #(.DW(DW)) u_align_2 (
        .rdata_i   (dm_rdata_2),
        .ld_type_i (mem_ld_type_2),
        .addr_lo_i (mem_addr_lo_2),
        .data_o    (ld_data_2)
    );

    // Per-lane write intent; $0 writes are dropped and the younger lane wins a WAW tie
    always_comb begin
        wr_1     = mem_valid_1 & mem_w_en_1 & (mem_w_addr_1 != AW'(REG_ZERO));
        wr_2     = mem_valid_2 & mem_w_en_2 & (mem_w_addr_2 != AW'(REG_ZERO));
        en_1_d   = wr_1 & ~(wr_2 & (mem_w_addr_1 == mem_w_addr_2));
        en_2_d   = wr_2;
        data_1_d = mem_is_load_1 ? ld_data_1 : mem_alu_data_1;
        data_2_d = mem_is_load_2 ? ld_data_2 : mem_alu_data_2;
        cnt_d    = cnt_q + CNT_W'(lanes_valid(mem_valid_1, mem_valid_2));
    end

    // Pipeline registers: flush beats stall, stall holds everything, else load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_1_q   <= 1'b0;
            en_2_q   <= 1'b0;
            addr_1_q <= '0;
            addr_2_q <= '0;
            data_1_q <= '0;
            data_2_q <= '0;
            cnt_q    <= '0;
        end else if (wb_flush) begin
            en_1_q   <= 1'b0;
            en_2_q   <= 1'b0;
            addr_1_q <= '0;
            addr_2_q <= '0;
            data_1_q <= '0;
            data_2_q <= '0;
        end else if (!wb_stall) begin
            en_1_q   <= en_1_d;
            en_2_q   <= en_2_d;
            addr_1_q <= mem_w_addr_1;
            addr_2_q <= mem_w_addr_2;
            data_1_q <= data_1_d;
            data_2_q <= data_2_d;
            cnt_q    <= cnt_d;
        end
    end

    assign reg_w_en_1    = en_1_q;
    assign reg_w_en_2    = en_2_q;
    assign reg_w_addr_1  = addr_1_q;
    assign reg_w_addr_2  = addr_2_q;
    assign reg_w_data_1  = data_1_q;
    assign reg_w_data_2  = data_2_q;
    assign wb_retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for the write-back stage
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        v1, v2, w1, w2, ld1, ld2, stall, flush;
    logic [4:0]  a1, a2;
    logic [31:0] alu1, alu2, dm;
    logic [2:0]  ty1, ty2;
    logic [1:0]  lo1, lo2;
    logic        en1, en2;
    logic [4:0]  oa1, oa2;
    logic [31:0] od1, od2, cnt;
    logic        s_en1, s_en2;
    logic [4:0]  s_a1, s_a2;
    logic [31:0] s_d1, s_d2;
    logic [3:0]  s_cnt;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .reset(reset),
        .mem_valid_1(v1), .mem_valid_2(v2), .mem_w_en_1(w1), .mem_w_en_2(w2),
        .mem_w_addr_1(a1), .mem_w_addr_2(a2), .mem_alu_data_1(alu1), .mem_alu_data_2(alu2),
        .mem_is_load_1(ld1), .mem_is_load_2(ld2), .mem_ld_type_1(ty1), .mem_ld_type_2(ty2),
        .mem_addr_lo_1(lo1), .mem_addr_lo_2(lo2), .dm_rdata_1(dm), .dm_rdata_2(dm),
        .wb_stall(stall), .wb_flush(flush),
        .reg_w_en_1(en1), .reg_w_en_2(en2), .reg_w_addr_1(oa1), .reg_w_addr_2(oa2),
        .reg_w_data_1(od1), .reg_w_data_2(od2), .wb_retire_cnt(cnt)
    );

    wb_stage #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset),
        .mem_valid_1(v1), .mem_valid_2(v2), .mem_w_en_1(w1), .mem_w_en_2(w2),
        .mem_w_addr_1(a1), .mem_w_addr_2(a2), .mem_alu_data_1(alu1), .mem_alu_data_2(alu2),
        .mem_is_load_1(ld1), .mem_is_load_2(ld2), .mem_ld_type_1(ty1), .mem_ld_type_2(ty2),
        .mem_addr_lo_1(lo1), .mem_addr_lo_2(lo2), .dm_rdata_1(dm), .dm_rdata_2(dm),
        .wb_stall(stall), .wb_flush(flush),
        .reg_w_en_1(s_en1), .reg_w_en_2(s_en2), .reg_w_addr_1(s_a1), .reg_w_addr_2(s_a2),
        .reg_w_data_1(s_d1), .reg_w_data_2(s_d2), .wb_retire_cnt(s_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic lane(input int k, input logic v, input logic w, input logic [4:0] a,
                        input logic [31:0] alu, input logic ld, input logic [2:0] ty,
                        input logic [1:0] lo);
        if (k == 1) begin
            v1 = v; w1 = w; a1 = a; alu1 = alu; ld1 = ld; ty1 = ty; lo1 = lo;
        end else begin
            v2 = v; w2 = w; a2 = a; alu2 = alu; ld2 = ld; ty2 = ty; lo2 = lo;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        stall = 0; flush = 0; dm = 32'h80FF7F01;
        lane(1, 0, 0, 0, 0, 0, 0, 0);
        lane(2, 0, 0, 0, 0, 0, 0, 0);
        #1 reset = 1'b0;
        #1;
        check("rst_en1", 32'(en1), 0);
        check("rst_en2", 32'(en2), 0);
        check("rst_data1", od1, 0);
        check("rst_cnt", cnt, 0);
        @(negedge clk) reset = 1'b1;

        lane(1, 1, 1, 3, 32'h12345678, 0, 0, 0);
        lane(2, 1, 1, 4, 32'hCAFEBABE, 0, 0, 0);
        step();
        check("pt_en1", 32'(en1), 1);
        check("pt_en2", 32'(en2), 1);
        check("pt_addr1", 32'(oa1), 3);
        check("pt_addr2", 32'(oa2), 4);
        check("pt_data1", od1, 32'h12345678);
        check("pt_data2", od2, 32'hCAFEBABE);
        check("pt_cnt", cnt, 2);

        lane(1, 1, 1, 5, 32'h0, 1, 3'd3, 2'd3);
        lane(2, 1, 1, 6, 32'h0, 1, 3'd4, 2'd1);
        step();
        check("lb_a3", od1, 32'hFFFFFF80);
        check("lbu_a1", od2, 32'h0000007F);
        lane(1, 1, 1, 5, 32'h0, 1, 3'd1, 2'd2);
        lane(2, 1, 1, 6, 32'h0, 1, 3'd2, 2'd0);
        step();
        check("lh_a2", od1, 32'hFFFF80FF);
        check("lhu_a0", od2, 32'h00007F01);
        lane(1, 1, 1, 5, 32'h0, 1, 3'd0, 2'd2);
        lane(2, 1, 1, 6, 32'h0, 1, 3'd7, 2'd1);
        step();
        check("lw", od1, 32'h80FF7F01);
        check("ld_bad_type", od2, 32'h80FF7F01);
        check("ld_cnt", cnt, 8);

        lane(1, 1, 1, 7, 32'd1, 0, 0, 0);
        lane(2, 1, 1, 7, 32'd2, 0, 0, 0);
        step();
        check("waw_en1", 32'(en1), 0);
        check("waw_en2", 32'(en2), 1);
        check("waw_data2", od2, 2);
        check("waw_cnt", cnt, 10);

        lane(1, 1, 1, 0, 32'd9, 0, 0, 0);
        lane(2, 1, 0, 9, 32'd9, 0, 0, 0);
        step();
        check("r0_en1", 32'(en1), 0);
        check("nowr_en2", 32'(en2), 0);
        check("r0_cnt", cnt, 12);

        lane(1, 1, 1, 8, 32'd5, 0, 0, 0);
        lane(2, 1, 0, 8, 32'd6, 0, 0, 0);
        step();
        check("nowaw_en1", 32'(en1), 1);
        check("nowaw_data1", od1, 5);

        lane(1, 1, 1, 10, 32'hAAAA0001, 0, 0, 0);
        lane(2, 1, 1, 11, 32'hBBBB0002, 0, 0, 0);
        step();
        check("pre_stall_cnt", cnt, 16);
        stall = 1;
        lane(1, 1, 1, 20, 32'hDEAD0000, 0, 0, 0);
        lane(2, 1, 1, 21, 32'hDEAD0001, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr1", 32'(oa1), 10);
            check("stall_data2", od2, 32'hBBBB0002);
            check("stall_en2", 32'(en2), 1);
            check("stall_cnt", cnt, 16);
        end
        flush = 1;
        step();
        check("flush_en1", 32'(en1), 0);
        check("flush_en2", 32'(en2), 0);
        check("flush_data1", od1, 0);
        check("flush_cnt", cnt, 16);
        flush = 0; stall = 0;
        lane(1, 1, 1, 12, 32'h55, 0, 0, 0);
        lane(2, 0, 1, 13, 32'h66, 0, 0, 0);
        step();
        check("rel_en1", 32'(en1), 1);
        check("rel_en2", 32'(en2), 0);
        check("rel_data1", od1, 32'h55);
        check("rel_cnt", cnt, 17);

        #2 reset = 1'b0;
        #1;
        check("async_en1", 32'(en1), 0);
        check("async_addr1", 32'(oa1), 0);
        check("async_data1", od1, 0);
        check("async_cnt", cnt, 0);
        check("async_small_cnt", 32'(s_cnt), 0);
        @(negedge clk) reset = 1'b1;

        lane(1, 1, 0, 0, 0, 0, 0, 0);
        lane(2, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step();
        check("small_cnt_15", 32'(s_cnt), 15);
        lane(2, 1, 0, 0, 0, 0, 0, 0);
        step();
        check("small_cnt_wrap", 32'(s_cnt), 1);
        check("big_cnt_17", cnt, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
